// File: rtl/hc165_if.sv
// Pin and host-side signal bundle for the 74HC165 chain reader.
// Handshake: scan_req is a one-cycle request accepted only while busy=0 (ignored otherwise, never queued);
// data_valid is a one-cycle pulse with no backpressure, data_changed is only meaningful alongside it.
interface hc165_if #(
    parameter int CHAIN_BITS = 16
);
    logic                  scan_req;
    logic                  q7;
    logic                  pl_n;
    logic                  cp;
    logic                  ce_n;
    logic                  busy;
    logic [CHAIN_BITS-1:0] data_out;
    logic                  data_valid;
    logic                  data_changed;
    logic [1:0]            fsm_state;

    modport slave (
        input  scan_req,
        input  q7,
        output pl_n,
        output cp,
        output ce_n,
        output busy,
        output data_out,
        output data_valid,
        output data_changed,
        output fsm_state
    );

    modport master (
        output scan_req,
        output q7,
        input  pl_n,
        input  cp,
        input  ce_n,
        input  busy,
        input  data_out,
        input  data_valid,
        input  data_changed,
        input  fsm_state
    );
endinterface

// File: rtl/hc165_reader.sv
// Scans a 74HC165 chain: parallel-load pulse, CHAIN_BITS shift clocks, MSB-first assembly,
// then a one-cycle data_valid/data_changed pulse. Every output comes straight from a flop.
module hc165_reader #(
    parameter int CHAIN_BITS    = 16,
    parameter int CLK_DIV       = 4,
    parameter int SCAN_INTERVAL = 50000
) (
    input logic    sys_clk,
    input logic    sys_rst_n,
    hc165_if.slave bus
);
    localparam int HALF = CLK_DIV / 2;
    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW   = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;
    localparam int IW   = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;

    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(HALF - 1);
    localparam logic [PW-1:0] PHASE_RISE   = PW'(HALF);
    localparam logic [BW-1:0] BIT_LAST     = BW'(CHAIN_BITS - 1);
    localparam logic [IW-1:0] IDLE_LAST    = IW'(SCAN_INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nx;
    logic [PW-1:0]         phase, phase_nx;
    logic [BW-1:0]         bit_cnt, bit_nx;
    logic [IW-1:0]         idle_cnt, idle_nx;
    logic [CHAIN_BITS-1:0] sr, sr_nx;

    logic                  pl_n_reg, pl_n_nx;
    logic                  cp_reg, cp_nx;
    logic                  busy_reg, busy_nx;
    logic                  valid_reg, valid_nx;
    logic                  changed_reg, changed_nx;
    logic [CHAIN_BITS-1:0] data_reg;

    logic                  auto_hit;

    assign auto_hit = (SCAN_INTERVAL != 0) && (idle_cnt == IDLE_LAST);

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        bit_nx   = bit_cnt;
        idle_nx  = idle_cnt;
        sr_nx    = sr;

        unique case (state)
            IDLE: begin
                if (bus.scan_req || auto_hit) begin
                    state_nx = LOAD;
                    idle_nx  = '0;
                    phase_nx = '0;
                end else begin
                    idle_nx = idle_cnt + IW'(1);
                end
            end
            LOAD: begin
                if (phase == PHASE_LAST) begin
                    state_nx = SHIFT;
                    phase_nx = '0;
                    bit_nx   = '0;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            SHIFT: begin
                // Last cp-low cycle: QH has been stable since the previous rising edge.
                if (phase == PHASE_SAMPLE) begin
                    sr_nx = CHAIN_BITS'({sr, bus.q7});
                end
                if (phase == PHASE_LAST) begin
                    phase_nx = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nx = DONE;
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_cnt + BW'(1);
                    end
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are registered from the next state so pins line up with the state they belong to.
        pl_n_nx    = (state_nx != LOAD);
        cp_nx      = (state_nx == SHIFT) && (phase_nx >= PHASE_RISE);
        busy_nx    = (state_nx != IDLE);
        valid_nx   = (state_nx == DONE);
        changed_nx = valid_nx && (sr_nx != data_reg);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            sr          <= '0;
            pl_n_reg    <= 1'b1;
            cp_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            changed_reg <= 1'b0;
            data_reg    <= '0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            bit_cnt     <= bit_nx;
            idle_cnt    <= idle_nx;
            sr          <= sr_nx;
            pl_n_reg    <= pl_n_nx;
            cp_reg      <= cp_nx;
            busy_reg    <= busy_nx;
            valid_reg   <= valid_nx;
            changed_reg <= changed_nx;
            if (valid_nx) begin
                data_reg <= sr_nx;
            end
        end
    end

    assign bus.pl_n         = pl_n_reg;
    assign bus.cp           = cp_reg;
    assign bus.ce_n         = 1'b0;
    assign bus.busy         = busy_reg;
    assign bus.data_out     = data_reg;
    assign bus.data_valid   = valid_reg;
    assign bus.data_changed = changed_reg;
    assign bus.fsm_state    = state;
endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader: two cascaded 165s modelled behaviourally, scans checked for pin timing
// and against an expected-word queue.
module tb_hc165_reader;
    localparam int W           = 16;
    localparam int DIV         = 4;
    localparam int INTERVAL    = 100;
    localparam int SCAN_LEN    = DIV * (W + 1) + 1;
    localparam int AUTO_PERIOD = INTERVAL + SCAN_LEN;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic [W-1:0] par;
    logic [W-1:0] chain;
    logic [W-1:0] model_prev;
    logic [W-1:0] exp_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           last_valid_cyc = 0;

    hc165_if #(.CHAIN_BITS(W)) bus ();

    hc165_reader #(
        .CHAIN_BITS   (W),
        .CLK_DIV      (DIV),
        .SCAN_INTERVAL(INTERVAL)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    // clock / cycle counter
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // 165 chain: parallel load while SH/LD is low, shift toward QH on cp rising edges
    always @(negedge bus.pl_n or posedge bus.cp) begin
        if (!bus.pl_n) chain <= par;
        else           chain <= chain << 1;
    end
    assign bus.q7 = chain[W-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pl_n"}, 32'(bus.pl_n), 1);
        check({tag, "_cp"}, 32'(bus.cp), 0);
        check({tag, "_ce_n"}, 32'(bus.ce_n), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_data_out"}, 32'(bus.data_out), 0);
        check({tag, "_data_valid"}, 32'(bus.data_valid), 0);
        check({tag, "_data_changed"}, 32'(bus.data_changed), 0);
        check({tag, "_state"}, 32'(bus.fsm_state), 0);
    endtask

    // scoreboard: each completed scan must deliver the oldest expected word
    task automatic score(input string tag, input logic [W-1:0] word, input logic chg);
        logic [W-1:0] exp_word;
        check({tag, "_exp_avail"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            check({tag, "_data_out"}, 32'(word), 32'(exp_word));
            check({tag, "_changed"}, 32'(chg), 32'(exp_word != model_prev));
            model_prev = exp_word;
        end
    endtask

    // request a scan and measure it; optionally pulse scan_req again at sample k=extra_at
    task automatic run_scan(input string tag, input int extra_at);
        int           pl_low, pl_first, cp_rise, busy_cyc, n_valid, valid_at;
        logic         prev_cp, chg;
        logic [W-1:0] word;
        pl_low = 0; pl_first = -1; cp_rise = 0; busy_cyc = 0; n_valid = 0; valid_at = -1;
        prev_cp = 1'b0; chg = 1'b0; word = '0;
        exp_q.push_back(par);
        @(negedge sys_clk);
        bus.scan_req = 1'b1;
        for (int k = 0; k < SCAN_LEN + 20; k++) begin
            @(negedge sys_clk);
            bus.scan_req = (k == extra_at);
            if (!bus.pl_n) begin
                pl_low++;
                if (pl_first < 0) pl_first = k;
            end
            if (bus.cp && !prev_cp) cp_rise++;
            prev_cp = bus.cp;
            if (bus.busy) busy_cyc++;
            if (bus.data_valid) begin
                n_valid++;
                valid_at = k;
                word = bus.data_out;
                chg = bus.data_changed;
                last_valid_cyc = cyc;
            end
            if (!bus.busy) break;
        end
        bus.scan_req = 1'b0;
        check({tag, "_pl_first"}, 32'(pl_first), 0);
        check({tag, "_pl_low"}, 32'(pl_low), DIV);
        check({tag, "_cp_rises"}, 32'(cp_rise), W);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), SCAN_LEN);
        check({tag, "_valid_at"}, 32'(valid_at), SCAN_LEN - 1);
        check({tag, "_valid_count"}, 32'(n_valid), 1);
        score(tag, word, chg);
        if (extra_at >= 0) begin
            n_valid = 0; busy_cyc = 0;
            repeat (20) begin
                @(negedge sys_clk);
                if (bus.data_valid) n_valid++;
                if (bus.busy) busy_cyc++;
            end
            check({tag, "_no_extra_valid"}, 32'(n_valid), 0);
            check({tag, "_no_extra_busy"}, 32'(busy_cyc), 0);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget, output int at,
                              output logic [W-1:0] word, output logic chg);
        at = -1; word = '0; chg = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (bus.data_valid) begin
                at = cyc;
                word = bus.data_out;
                chg = bus.data_changed;
                break;
            end
        end
        check({tag, "_seen"}, 32'(at >= 0), 1);
    endtask

    initial begin
        int           t1, t2, n_valid;
        logic [W-1:0] w;
        logic         c;

        bus.scan_req = 1'b0;
        sys_rst_n    = 1'b0;
        par          = 16'hA5C3;
        model_prev   = '0;

        repeat (5) @(negedge sys_clk);
        check_reset_vals("reset");
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        run_scan("req", -1);
        run_scan("repeat", -1);

        // auto-scan: no requests, new input value
        par = 16'h0001;
        exp_q.push_back(par);
        wait_valid("auto1", 400, t1, w, c);
        check("auto1_gap", 32'(t1 - last_valid_cyc), AUTO_PERIOD);
        score("auto1", w, c);
        exp_q.push_back(par);
        wait_valid("auto2", 400, t2, w, c);
        check("auto2_gap", 32'(t2 - t1), AUTO_PERIOD);
        score("auto2", w, c);

        // request ten cycles into SHIFT must be ignored
        par = 16'h3C5A;
        run_scan("busy_req", DIV + 10);

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 2) == 0) par = model_prev;
            else                           par = W'($urandom);
            repeat ($urandom_range(1, 60)) @(negedge sys_clk);
            run_scan($sformatf("rand%0d", i), -1);
        end

        // reset during bit 7 of SHIFT
        par = W'($urandom);
        @(negedge sys_clk);
        bus.scan_req = 1'b1;
        @(negedge sys_clk);
        bus.scan_req = 1'b0;
        repeat (DIV + 7 * DIV + 1) @(negedge sys_clk);
        check("mid_busy", 32'(bus.busy), 1);
        sys_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        n_valid = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (bus.data_valid) n_valid++;
        end
        sys_rst_n = 1'b1;
        model_prev = '0;
        repeat (30) begin
            @(negedge sys_clk);
            if (bus.data_valid) n_valid++;
        end
        check("rst_mid_no_valid", 32'(n_valid), 0);
        check("rst_mid_data_out", 32'(bus.data_out), 0);
        par = 16'hA5C3;
        run_scan("post_rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
